alu_control_fsm: RTL and testbench

Multi-cycle ALU control sequencer that sits directly upstream of the 16-bit ALU result-select multiplexer. It accepts an opcode with a Start strobe and drives the 3-bit result-select code and the operand-invert and carry controls. It also runs iterated single-bit shifts through the datapath working register and issues one register-file writeback pulse per operation, together with Done and IllegalOp status.

---
 rtl/alu_control_fsm.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_control_fsm.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_fsm.sv
// -----------------------------------------------------------------------------
// alu_control_fsm
//
// Multi-cycle control sequencer for the 16-bit ALU result-select multiplexer.
// An operation is requested with Start in IDLE; the opcode and shift amount
// are captured on that edge. The FSM then walks LOAD -> (EXEC | SHIFT*) -> WB
// and returns to IDLE. Shifts are performed as ShAmt single-bit iterations
// through the datapath working register W.
//
// All outputs are registers. Their next values are decoded from the next state
// and the next latched opcode, so each output changes on the same edge as the
// state. There is no combinational path from any input to any output.
//
// Ports
//   Clock        in   rising-edge clock
//   Reset        in   synchronous, active-low reset
//   Start        in   operation request, sampled only in IDLE
//   Opcode[3:0]  in   operation code, captured on the accepted Start edge
//   ShAmt[3:0]   in   shift amount 0..15, captured with Opcode
//   S[2:0]       out  result-select code for the 6:1 result mux
//   AInvert      out  invert operand A
//   BInvert      out  invert operand B
//   CarryIn      out  adder carry-in (1 for SUB)
//   OpLoad       out  one-cycle pulse: load operand registers, W <= A
//   ShiftStep    out  per-iteration pulse: W <= mux output
//   WbFromShift  out  writeback source: 1 = W, 0 = mux output
//   RegWrite     out  one-cycle register-file write pulse
//   Busy         out  high in every state except IDLE
//   Done         out  one-cycle completion pulse
//   IllegalOp    out  high with Done for an undefined opcode
// -----------------------------------------------------------------------------
module alu_control_fsm (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [3:0] Opcode,
  input  logic [3:0] ShAmt,
  output logic [2:0] S,
  output logic       AInvert,
  output logic       BInvert,
  output logic       CarryIn,
  output logic       OpLoad,
  output logic       ShiftStep,
  output logic       WbFromShift,
  output logic       RegWrite,
  output logic       Busy,
  output logic       Done,
  output logic       IllegalOp
);

  // One-hot state encoding; any non-legal pattern recovers to IDLE.
  localparam logic [4:0] ST_IDLE  = 5'b00001;
  localparam logic [4:0] ST_LOAD  = 5'b00010;
  localparam logic [4:0] ST_EXEC  = 5'b00100;
  localparam logic [4:0] ST_SHIFT = 5'b01000;
  localparam logic [4:0] ST_WB    = 5'b10000;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b0111;

  // Result-mux select codes.
  localparam logic [2:0] SEL_AND = 3'b000;
  localparam logic [2:0] SEL_OR  = 3'b010;
  localparam logic [2:0] SEL_SUM = 3'b001;
  localparam logic [2:0] SEL_XOR = 3'b011;
  localparam logic [2:0] SEL_SLL = 3'b111;
  localparam logic [2:0] SEL_SRL = 3'b110;

  // Packed datapath controls: {S[2:0], AInvert, BInvert, CarryIn, WbFromShift}.
  // Illegal opcodes decode to all-zero so the mux controls stay quiet.
  function automatic logic [6:0] decode_ctrl(input logic [3:0] op);
    logic [6:0] ctrl;
    case (op)
      OP_AND:  ctrl = {SEL_AND, 1'b0, 1'b0, 1'b0, 1'b0};
      OP_OR:   ctrl = {SEL_OR,  1'b0, 1'b0, 1'b0, 1'b0};
      OP_ADD:  ctrl = {SEL_SUM, 1'b0, 1'b0, 1'b0, 1'b0};
      OP_SUB:  ctrl = {SEL_SUM, 1'b0, 1'b1, 1'b1, 1'b0};
      OP_XOR:  ctrl = {SEL_XOR, 1'b0, 1'b0, 1'b0, 1'b0};
      OP_SLL:  ctrl = {SEL_SLL, 1'b0, 1'b0, 1'b0, 1'b1};
      OP_SRL:  ctrl = {SEL_SRL, 1'b0, 1'b0, 1'b0, 1'b1};
      OP_NOR:  ctrl = {SEL_AND, 1'b1, 1'b1, 1'b0, 1'b0};
      default: ctrl = 7'b000_0000;
    endcase
    return ctrl;
  endfunction

  // Opcodes 1000..1111 are undefined.
  function automatic logic is_legal(input logic [3:0] op);
    return (op[3] == 1'b0);
  endfunction

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

  logic [4:0] state_r;
  logic [4:0] state_nxt_s;
  logic [3:0] op_r;
  logic [3:0] op_nxt_s;
  logic [3:0] sh_r;
  logic [3:0] sh_nxt_s;
  logic [3:0] cnt_r;
  logic [3:0] cnt_nxt_s;

  logic [6:0] ctrl_r;
  logic [6:0] ctrl_nxt_s;
  logic       op_load_r;
  logic       shift_step_r;
  logic       reg_write_r;
  logic       busy_r;
  logic       done_r;
  logic       illegal_r;

  logic       nxt_is_wb_s;
  logic       nxt_legal_s;

  // Next-state, operand-latch and shift-counter logic.
  always_comb begin
    state_nxt_s = ST_IDLE;
    op_nxt_s    = op_r;
    sh_nxt_s    = sh_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          state_nxt_s = ST_LOAD;
          op_nxt_s    = Opcode;
          sh_nxt_s    = ShAmt;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (!is_legal(op_r)) begin
          state_nxt_s = ST_WB;
        end else if (is_shift(op_r)) begin
          if (sh_r == 4'd0) begin
            // Zero-length shift writes back the unshifted A held in W.
            state_nxt_s = ST_WB;
          end else begin
            state_nxt_s = ST_SHIFT;
            cnt_nxt_s   = sh_r;
          end
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_nxt_s = ST_WB;
      end
      ST_SHIFT: begin
        // Leaving on count==1 yields exactly ShAmt ShiftStep cycles; a
        // corrupted zero count also exits rather than wrapping to 15.
        if (cnt_r <= 4'd1) begin
          state_nxt_s = ST_WB;
          cnt_nxt_s   = 4'd0;
        end else begin
          state_nxt_s = ST_SHIFT;
          cnt_nxt_s   = cnt_r - 4'd1;
        end
      end
      ST_WB: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // Output decode for the upcoming state, so outputs register alongside it.
  always_comb begin
    nxt_is_wb_s = (state_nxt_s == ST_WB);
    nxt_legal_s = is_legal(op_nxt_s);
    if (state_nxt_s != ST_IDLE) begin
      ctrl_nxt_s = decode_ctrl(op_nxt_s);
    end else begin
      ctrl_nxt_s = 7'b000_0000;
    end
  end

  // State, latched operation and registered outputs.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_r      <= ST_IDLE;
      op_r         <= 4'd0;
      sh_r         <= 4'd0;
      cnt_r        <= 4'd0;
      ctrl_r       <= 7'b000_0000;
      op_load_r    <= 1'b0;
      shift_step_r <= 1'b0;
      reg_write_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      illegal_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      op_r         <= op_nxt_s;
      sh_r         <= sh_nxt_s;
      cnt_r        <= cnt_nxt_s;
      ctrl_r       <= ctrl_nxt_s;
      op_load_r    <= (state_nxt_s == ST_LOAD);
      shift_step_r <= (state_nxt_s == ST_SHIFT);
      reg_write_r  <= nxt_is_wb_s && nxt_legal_s;
      busy_r       <= (state_nxt_s != ST_IDLE);
      done_r       <= nxt_is_wb_s;
      illegal_r    <= nxt_is_wb_s && !nxt_legal_s;
    end
  end

  assign S           = ctrl_r[6:4];
  assign AInvert     = ctrl_r[3];
  assign BInvert     = ctrl_r[2];
  assign CarryIn     = ctrl_r[1];
  assign WbFromShift = ctrl_r[0];
  assign OpLoad      = op_load_r;
  assign ShiftStep   = shift_step_r;
  assign RegWrite    = reg_write_r;
  assign Busy        = busy_r;
  assign Done        = done_r;
  assign IllegalOp   = illegal_r;

endmodule

// File: tb/tb_alu_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_alu_control_fsm
//
// Self-checking bench for alu_control_fsm. Expected per-cycle output vectors
// come from a behavioural model built from the opcode table and the operation
// length rules (LOAD, then EXEC or ShAmt shift cycles, then WB).
// Vector layout: {S[2:0], AInvert, BInvert, CarryIn, OpLoad, ShiftStep,
//                 WbFromShift, RegWrite, Busy, Done, IllegalOp}
// -----------------------------------------------------------------------------
module tb_alu_control_fsm;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic [3:0] Opcode = 4'd0;
  logic [3:0] ShAmt = 4'd0;
  logic [2:0] S;
  logic       AInvert, BInvert, CarryIn, OpLoad, ShiftStep, WbFromShift;
  logic       RegWrite, Busy, Done, IllegalOp;

  int errors = 0;
  int checks = 0;

  alu_control_fsm dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Opcode(Opcode), .ShAmt(ShAmt),
    .S(S), .AInvert(AInvert), .BInvert(BInvert), .CarryIn(CarryIn),
    .OpLoad(OpLoad), .ShiftStep(ShiftStep), .WbFromShift(WbFromShift),
    .RegWrite(RegWrite), .Busy(Busy), .Done(Done), .IllegalOp(IllegalOp)
  );

  always #5 Clock = ~Clock;

  logic [12:0] obs;
  assign obs = {S, AInvert, BInvert, CarryIn, OpLoad, ShiftStep, WbFromShift,
                RegWrite, Busy, Done, IllegalOp};

  // Opcode table: {S, AInvert, BInvert, CarryIn}
  function automatic logic [5:0] ctrl_of(input logic [3:0] opc);
    case (opc)
      4'd0:    return 6'b000_000;
      4'd1:    return 6'b010_000;
      4'd2:    return 6'b001_000;
      4'd3:    return 6'b001_011;
      4'd4:    return 6'b011_000;
      4'd5:    return 6'b111_000;
      4'd6:    return 6'b110_000;
      4'd7:    return 6'b000_110;
      default: return 6'b000_000;
    endcase
  endfunction

  // Number of busy cycles from LOAD through WB inclusive.
  function automatic int op_len(input logic [3:0] opc, input logic [3:0] sh);
    if (opc >= 4'd8) return 2;
    if (opc == 4'd5 || opc == 4'd6) return int'(sh) + 2;
    return 3;
  endfunction

  // Expected outputs in busy cycle j (1 = LOAD, op_len = WB).
  function automatic logic [12:0] exp_vec(input logic [3:0] opc, input logic [3:0] sh, input int j);
    int   len;
    logic legal, shift;
    len   = op_len(opc, sh);
    legal = (opc < 4'd8);
    shift = (opc == 4'd5) || (opc == 4'd6);
    return {ctrl_of(opc), (j == 1), (shift && j >= 2 && j < len), shift,
            (j == len && legal), 1'b1, (j == len), (j == len && !legal)};
  endfunction

  // One operation: accept, then compare every busy cycle and the idle after.
  task automatic run_op(input logic [3:0] opc, input logic [3:0] sh);
    int len;
    logic [12:0] e;
    for (int t = 0; t < 40 && Busy; t++) begin
      @(posedge Clock); #1;
    end
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_wait: Busy=%b required 0 before op %h", Busy, opc);
    end
    @(negedge Clock);
    Start = 1'b1; Opcode = opc; ShAmt = sh;
    @(posedge Clock); #1;
    // Inputs changing after acceptance must not matter.
    Start = 1'b0; Opcode = 4'($urandom_range(15)); ShAmt = 4'($urandom_range(15));
    len = op_len(opc, sh);
    for (int j = 1; j <= len; j++) begin
      if (j > 1) begin
        @(posedge Clock); #1;
      end
      e = exp_vec(opc, sh, j);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL op%h_sh%0d_cyc%0d: got %b required %b", opc, sh, j, obs, e);
      end
    end
    @(posedge Clock); #1;
    checks++;
    if ({OpLoad, ShiftStep, RegWrite, Busy, Done, IllegalOp} !== 6'b0) begin
      errors++;
      $display("FAIL op%h_idle_after: got %b required 000000", opc,
               {OpLoad, ShiftStep, RegWrite, Busy, Done, IllegalOp});
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      checks++;
      if (obs !== 13'd0) begin
        errors++;
        $display("FAIL reset_init_%0d: got %b required 0", i, obs);
      end
    end
    @(negedge Clock); Reset = 1'b1;
    // Start an ADD, then reset it mid-stream for three cycles.
    @(negedge Clock); Start = 1'b1; Opcode = 4'd2; ShAmt = 4'd0;
    @(negedge Clock); Start = 1'b0;
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      checks++;
      if (obs !== 13'd0) begin
        errors++;
        $display("FAIL reset_mid_%0d: got %b required 0", i, obs);
      end
    end
    @(negedge Clock); Reset = 1'b1;
    run_op(4'd0, 4'd3);
  endtask

  task automatic test_sub();
    run_op(4'd3, 4'd9);
  endtask

  task automatic test_shift();
    run_op(4'd5, 4'd5);
    run_op(4'd5, 4'd15);
    run_op(4'd5, 4'd0);
    run_op(4'd6, 4'd1);
  endtask

  task automatic test_illegal();
    run_op(4'd10, 4'd4);
    run_op(4'd15, 4'd0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      run_op(4'($urandom_range(15)), 4'($urandom_range(15)));
    end
  endtask

  // Start held high: one OR every 4 clock edges (LOAD, EXEC, WB, one IDLE).
  task automatic test_back_to_back();
    int dones;
    logic [12:0] e;
    dones = 0;
    @(negedge Clock);
    Start = 1'b1; Opcode = 4'd1; ShAmt = 4'd0;
    for (int c = 0; c < 12; c++) begin
      @(posedge Clock); #1;
      e = ((c % 4) == 3) ? 13'd0 : exp_vec(4'd1, 4'd0, (c % 4) + 1);
      if (Done === 1'b1) dones++;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL b2b_cyc%0d: got %b required %b", c, obs, e);
      end
    end
    @(negedge Clock); Start = 1'b0;
    checks++;
    if (dones != 3) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d required 3", dones);
    end
    @(posedge Clock); #1;
  endtask

  task automatic test_reset_in_shift();
    int bad;
    @(negedge Clock);
    Start = 1'b1; Opcode = 4'd6; ShAmt = 4'd8;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (4) @(posedge Clock);
    #1;
    checks++;
    if (obs !== exp_vec(4'd6, 4'd8, 5)) begin
      errors++;
      $display("FAIL srl_pre_reset: got %b required %b", obs, exp_vec(4'd6, 4'd8, 5));
    end
    @(negedge Clock); Reset = 1'b0;
    @(posedge Clock); #1;
    checks++;
    if (obs !== 13'd0) begin
      errors++;
      $display("FAIL srl_reset_abort: got %b required 0", obs);
    end
    @(negedge Clock); Reset = 1'b1;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge Clock); #1;
      if (Done !== 1'b0 || RegWrite !== 1'b0 || Busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL srl_no_writeback: got %0d active cycles required 0", bad);
    end
    run_op(4'd7, 4'd2);
  endtask

  initial begin
    test_reset();
    test_sub();
    test_shift();
    test_illegal();
    test_back_to_back();
    test_reset_in_shift();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
